// File: rtl/axi_lite_sram_slave_pkg.sv
// axi_lite_sram_slave_pkg: response codes and channel FSM encodings shared by the SRAM slave
package axi_lite_sram_slave_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
endpackage

// File: rtl/axi_lite_sram_slave_sram_1r1w_bytemask.sv
// sram_1r1w_bytemask: word array with byte-masked write and registered read (old data on collision)
module sram_1r1w_bytemask #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     wstrb,
  input  logic                           re,
  input  logic                           rzero,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [31:0]                    rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d;
  assign rdata = rdata_q;
  always_comb rdata_d = re ? (rzero ? '0 : mem[raddr]) : rdata_q;
  always_ff @(posedge clock) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    rdata_q <= reset ? '0 : rdata_d;
  end
endmodule

// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI4-Lite subordinate over a byte-masked SRAM window
// with independent read/write channels, programmable latency and DECERR outside the window.
module axi_lite_sram_slave
  import axi_lite_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter int          DEPTH_WORDS   = 4096,
  parameter int          READ_LATENCY  = 1,
  parameter int          WRITE_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_slave_awvalid,
  output logic        io_slave_awready,
  input  logic [31:0] io_slave_awaddr,
  input  logic        io_slave_wvalid,
  output logic        io_slave_wready,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  output logic        io_slave_bvalid,
  input  logic        io_slave_bready,
  output logic [1:0]  io_slave_bresp,
  input  logic        io_slave_arvalid,
  output logic        io_slave_arready,
  input  logic [31:0] io_slave_araddr,
  output logic        io_slave_rvalid,
  input  logic        io_slave_rready,
  output logic [31:0] io_slave_rdata,
  output logic [1:0]  io_slave_rresp
);
  localparam int          AW  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN = 32'(4 * DEPTH_WORDS);
  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic [3:0]  wstrb_q, wstrb_d, wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] woff, roff;
  logic        w_in, r_in, w_commit, r_commit;
  // Unsigned offset wraps for addresses below the base, so one compare covers both bounds.
  assign woff = awaddr_q - BASE_ADDR;
  assign roff = araddr_q - BASE_ADDR;
  assign w_in = woff < WIN;
  assign r_in = roff < WIN;
  assign io_slave_awready = awready_q;
  assign io_slave_wready  = wready_q;
  assign io_slave_bvalid  = bvalid_q;
  assign io_slave_bresp   = bresp_q;
  assign io_slave_arready = arready_q;
  assign io_slave_rvalid  = rvalid_q;
  assign io_slave_rresp   = rresp_q;
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wcnt_d    = wcnt_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    w_commit  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (io_slave_awvalid && awready_q) begin
          aw_got_d = 1'b1;
          awaddr_d = io_slave_awaddr;
        end
        if (io_slave_wvalid && wready_q) begin
          w_got_d = 1'b1;
          wdata_d = io_slave_wdata;
          wstrb_d = io_slave_wstrb;
        end
        awready_d = !aw_got_d;
        wready_d  = !w_got_d;
        if (aw_got_d && w_got_d) begin
          w_state_d = W_WAIT;
          wcnt_d    = 4'(WRITE_LATENCY);
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) begin
          w_commit  = 1'b1;
          bvalid_d  = 1'b1;
          bresp_d   = w_in ? RESP_OKAY : RESP_DECERR;
          w_state_d = W_RESP;
        end else wcnt_d = wcnt_q - 4'd1;
      end
      W_RESP: begin
        if (io_slave_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rcnt_d    = rcnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    r_commit  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (io_slave_arvalid && arready_q) begin
          araddr_d  = io_slave_araddr;
          arready_d = 1'b0;
          rcnt_d    = 4'(READ_LATENCY);
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          r_commit  = 1'b1;
          rvalid_d  = 1'b1;
          rresp_d   = r_in ? RESP_OKAY : RESP_DECERR;
          r_state_d = R_RESP;
        end else rcnt_d = rcnt_q - 4'd1;
      end
      R_RESP: begin
        if (io_slave_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
    araddr_q <= araddr_d;
    wcnt_q   <= wcnt_d;
    rcnt_q   <= rcnt_d;
    if (reset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end
  sram_1r1w_bytemask #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clock (clock),
    .reset (reset),
    .we    (w_commit && w_in && !reset),
    .waddr (woff[AW+1:2]),
    .wdata (wdata_q),
    .wstrb (wstrb_q),
    .re    (r_commit),
    .rzero (!r_in),
    .raddr (roff[AW+1:2]),
    .rdata (io_slave_rdata)
  );
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// tb_axi_lite_sram_slave: directed AXI-Lite traffic checked every cycle against a
// timestamp-based behavioural model plus hand-computed literal expectations.
module tb_axi_lite_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int RL = 1;
  localparam int WL = 1;
  logic clock = 1'b0, reset = 1'b1;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int checks = 0, errors = 0;

  axi_lite_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(4096), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clock(clock), .reset(reset),
    .io_slave_awvalid(awvalid), .io_slave_awready(awready), .io_slave_awaddr(awaddr),
    .io_slave_wvalid(wvalid), .io_slave_wready(wready), .io_slave_wdata(wdata), .io_slave_wstrb(wstrb),
    .io_slave_bvalid(bvalid), .io_slave_bready(bready), .io_slave_bresp(bresp),
    .io_slave_arvalid(arvalid), .io_slave_arready(arready), .io_slave_araddr(araddr),
    .io_slave_rvalid(rvalid), .io_slave_rready(rready), .io_slave_rdata(rdata), .io_slave_rresp(rresp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h4000);
  endfunction

  // Model: expected outputs for the next cycle, with response due-times as cycle stamps.
  int cyc = 0, r_due = 0, w_due = 0, mk;
  logic armed = 0;
  logic e_arready, e_rvalid, e_awready, e_wready, e_bvalid, e_rknown;
  logic [31:0] e_rdata, r_addr, w_addr, w_data, mo;
  logic [1:0] e_rresp, e_bresp;
  logic [3:0] w_strb;
  logic r_pend = 0, w_pend = 0, aw_got = 0, w_got = 0;
  logic [31:0] mm [int];

  always @(negedge clock) begin
    cyc++;
    if (armed) begin
      chk("arready", 32'(arready), 32'(e_arready));
      chk("awready", 32'(awready), 32'(e_awready));
      chk("wready", 32'(wready), 32'(e_wready));
      chk("rvalid", 32'(rvalid), 32'(e_rvalid));
      chk("bvalid", 32'(bvalid), 32'(e_bvalid));
      if (e_rvalid) chk("rresp", 32'(rresp), 32'(e_rresp));
      if (e_rvalid && e_rknown) chk("rdata", rdata, e_rdata);
      if (e_bvalid) chk("bresp", 32'(bresp), 32'(e_bresp));
    end
    if (reset) begin
      armed = 1;
      {e_arready, e_rvalid, e_awready, e_wready, e_bvalid} = '0;
      {r_pend, w_pend, aw_got, w_got} = '0;
      e_rresp = 0; e_bresp = 0;
    end else begin
      if (e_rvalid) begin
        if (rready) begin e_rvalid = 0; e_arready = 1; end
      end else if (r_pend) begin
        if (cyc + 1 == r_due) begin
          r_pend = 0; e_rvalid = 1;
          mk = int'((r_addr - BASE) >> 2);
          e_rresp = in_win(r_addr) ? 2'b00 : 2'b11;
          e_rknown = !in_win(r_addr) || mm.exists(mk);
          e_rdata = !in_win(r_addr) ? 32'h0 : (mm.exists(mk) ? mm[mk] : 32'h0);
        end
      end else if (e_arready && arvalid) begin
        r_pend = 1; r_addr = araddr; r_due = cyc + 2 + RL; e_arready = 0;
      end else e_arready = 1;
      if (e_bvalid) begin
        if (bready) begin e_bvalid = 0; e_awready = 1; e_wready = 1; aw_got = 0; w_got = 0; end
      end else if (w_pend) begin
        if (cyc + 1 == w_due) begin
          w_pend = 0; e_bvalid = 1;
          e_bresp = in_win(w_addr) ? 2'b00 : 2'b11;
          if (in_win(w_addr)) begin
            mk = int'((w_addr - BASE) >> 2);
            mo = mm.exists(mk) ? mm[mk] : 32'h0;
            for (int i = 0; i < 4; i++) if (w_strb[i]) mo[8*i +: 8] = w_data[8*i +: 8];
            mm[mk] = mo;
          end
        end
      end else begin
        if (e_awready && awvalid) begin aw_got = 1; w_addr = awaddr; end
        if (e_wready && wvalid) begin w_got = 1; w_data = wdata; w_strb = wstrb; end
        e_awready = !aw_got; e_wready = !w_got;
        if (aw_got && w_got) begin w_pend = 1; w_due = cyc + 2 + WL; end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic rd(input logic [31:0] a, input int stall, output logic [31:0] d, output logic [1:0] r, output int lat);
    int n = 0;
    araddr = a; arvalid = 1;
    while (!arready && n < 50) begin tick(); n++; end
    if (n == 50) tmo("arready");
    tick(); arvalid = 0; lat = 0;
    while (!rvalid && lat < 50) begin tick(); lat++; end
    if (lat == 50) tmo("rvalid");
    d = rdata; r = rresp;
    repeat (stall) tick();
    rready = 1; tick(); rready = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead, input int stall,
                    output logic [1:0] r, output int lat);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s;
    if (lead > 0) begin
      wvalid = 1;
      while (!wready && n < 50) begin tick(); n++; end
      tick(); wvalid = 0;
      repeat (lead - 1) tick();
      awvalid = 1;
      while (!awready && n < 50) begin tick(); n++; end
      tick(); awvalid = 0;
    end else begin
      awvalid = 1; wvalid = 1;
      while (!(awready && wready) && n < 50) begin tick(); n++; end
      tick(); awvalid = 0; wvalid = 0;
    end
    if (n >= 50) tmo("aw_w_ready");
    lat = 0;
    while (!bvalid && lat < 50) begin tick(); lat++; end
    if (lat == 50) tmo("bvalid");
    r = bresp;
    repeat (stall) tick();
    bready = 1; tick(); bready = 0;
  endtask

  logic [31:0] d, d2;
  logic [1:0] r, r2;
  int lat, lat2;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_arready", 32'(arready), 0);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resps", 32'({bresp, rresp}), 0);
    reset = 0; tick();
    chk("post_rst_readies", 32'({arready, awready, wready}), 32'b111);
    wr(32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, 0, r, lat);
    wr(32'h8000_0004, 32'hAABBCCDD, 4'hF, 0, 0, r, lat);
    wr(32'h8000_0000, 32'h0BADF00D, 4'hF, 0, 0, r, lat);
    wr(32'h8000_0020, 32'h0000_0001, 4'hF, 0, 0, r, lat);
    wr(32'h8000_0030, 32'h0000_0055, 4'hF, 0, 0, r, lat);
    wr(32'h8000_3FFC, 32'hCAFEF00D, 4'hF, 0, 0, r, lat);
    chk("wr_lat_same_cycle", lat, 2);
    rd(32'h8000_0010, 0, d, r, lat);
    chk("rd_lat", lat, 2);
    chk("rd_data", d, 32'hDEADBEEF);
    chk("rd_resp", 32'(r), 0);
    wr(32'h8000_0004, 32'h11223344, 4'b0101, 3, 0, r, lat);
    chk("wr_lead_lat", lat, 2);
    chk("wr_lead_resp", 32'(r), 0);
    rd(32'h8000_0004, 0, d, r, lat);
    chk("strb_merge", d, 32'hAA22CC44);
    rd(32'h7FFF_FFFC, 0, d, r, lat);
    chk("low_oob_resp", 32'(r), 32'h3);
    chk("low_oob_data", d, 0);
    wr(32'h8000_4000, 32'hFFFFFFFF, 4'hF, 0, 0, r, lat);
    chk("high_oob_bresp", 32'(r), 32'h3);
    rd(32'h8000_0000, 0, d, r, lat);
    chk("oob_no_alias", d, 32'h0BADF00D);
    rd(32'h8000_3FFC, 0, d, r, lat);
    chk("top_word", d, 32'hCAFEF00D);
    chk("top_word_resp", 32'(r), 0);
    fork
      rd(32'h8000_0010, 5, d, r, lat);
      wr(32'h8000_0014, 32'h12345678, 4'hF, 0, 5, r2, lat2);
    join
    chk("stall_rdata", d, 32'hDEADBEEF);
    wr(32'h8000_0014, 32'hFFFFFFFF, 4'h0, 0, 0, r, lat);
    chk("zero_strb_resp", 32'(r), 0);
    rd(32'h8000_0014, 0, d, r, lat);
    chk("zero_strb_data", d, 32'h12345678);
    fork
      wr(32'h8000_0020, 32'h0000_0002, 4'hF, 0, 0, r2, lat2);
      rd(32'h8000_0020, 0, d, r, lat);
    join
    chk("collide_old", d, 32'h1);
    rd(32'h8000_0020, 0, d, r, lat);
    chk("collide_new", d, 32'h2);
    awaddr = 32'h8000_0030; wdata = 32'h99; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; tick();
    awvalid = 0; wvalid = 0; reset = 1; tick();
    reset = 0; tick();
    chk("rst_mid_readies", 32'({arready, awready, wready}), 32'b111);
    chk("rst_mid_bvalid", 32'(bvalid), 0);
    repeat (4) tick();
    rd(32'h8000_0030, 0, d, r, lat);
    chk("rst_mid_unchanged", d, 32'h55);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
